// File: rtl/csa_sched.sv
// Round-robin scheduler sharing one pipelined CSA-N adder among NUM_REQ requesters.
// Results return through a credit-protected FWFT FIFO, tagged with the owning requester.
module csa_sched #(
  parameter int WIDTH         = 32,
  parameter int INPUT_VEC_LEN = 8,
  parameter int NUM_REQ       = 4,
  parameter int PIPE_LAT      = 3,
  parameter int FIFO_DEPTH    = PIPE_LAT + 1,
  localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_REQ-1:0]                               req_valid,
  output logic [NUM_REQ-1:0]                               req_ready,
  input  logic [NUM_REQ-1:0][INPUT_VEC_LEN-1:0][WIDTH-1:0] req_vec,
  output logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]              csa_in,
  input  logic [WIDTH-1:0]                                 csa_s,
  output logic                                             res_valid,
  input  logic                                             res_ready,
  output logic [WIDTH-1:0]                                 res_sum,
  output logic [IW-1:0]                                    res_id,
  output logic                                             busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [IW-1:0]                 ptr, grant_id;
  logic [2*NUM_REQ-1:0]          rot;
  logic                          found, issue, pop, push;
  logic [PIPE_LAT-1:0]           vld_pipe;
  logic [PIPE_LAT-1:0][IW-1:0]   id_pipe;
  logic [FIFO_DEPTH-1:0][WIDTH-1:0] fifo_sum;
  logic [FIFO_DEPTH-1:0][IW-1:0]    fifo_id;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count, credits;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign res_valid = !rst && (count != '0);
  assign pop       = res_valid && res_ready;
  assign push      = vld_pipe[PIPE_LAT-1];
  assign res_sum   = fifo_sum[rd_ptr];
  assign res_id    = fifo_id[rd_ptr];
  assign busy      = !rst && ((|vld_pipe) || (count != '0));

  // Rotate so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    rot      = {req_valid, req_valid} >> ptr;
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found    = 1'b1;
        grant_id = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // A pop this cycle frees a slot, so issue may proceed even from zero credits.
  assign issue     = !rst && found && ((credits != '0) || pop);
  assign req_ready = issue ? (NUM_REQ'(1) << grant_id) : '0;
  assign csa_in    = issue ? req_vec[grant_id] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      credits  <= CW'(FIFO_DEPTH);
    end else begin
      if (issue) ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      vld_pipe[0] <= issue;
      id_pipe[0]  <= grant_id;
      for (int k = 1; k < PIPE_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_sum[wr_ptr] <= csa_s;
      fifo_id[wr_ptr]  <= id_pipe[PIPE_LAT-1];
    end
  end

endmodule

// File: doc/csa_sched.md
CSA_SCHED -- requirements
Module: csa_sched

Interface
- REQ-001: Parameter WIDTH, default 32, SHALL set the operand and sum width in bits.
- REQ-002: Parameter INPUT_VEC_LEN, default 8, SHALL set the number of operands per request vector.
- REQ-003: Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one pipelined CSA-N adder.
- REQ-004: Parameter PIPE_LAT, default 3, SHALL set the adder latency in cycles, from csa_in to csa_s.
- REQ-005: Parameter FIFO_DEPTH, default PIPE_LAT+1, SHALL set the result FIFO depth; it SHALL be at least 1.
- REQ-006: The design SHALL use one clock; reset is synchronous and active-high.
- REQ-007: Port clk, input, 1 bit, SHALL be the single rising-edge clock.
- REQ-008: Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
- REQ-009: Port req_valid, input, NUM_REQ bits, SHALL flag that requester i presents a vector.
- REQ-010: Port req_ready, output, NUM_REQ bits, SHALL be the one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- REQ-011: Port req_vec, input, NUM_REQ x INPUT_VEC_LEN x WIDTH, SHALL carry the operand vectors per requester.
- REQ-012: Port csa_in, output, INPUT_VEC_LEN x WIDTH, SHALL drive the adder operands.
- REQ-013: Port csa_s, input, WIDTH, SHALL receive the adder sum, valid PIPE_LAT cycles after the matching csa_in.
- REQ-014: Port res_valid, output, 1 bit, SHALL flag that a result is available.
- REQ-015: Port res_ready, input, 1 bit, SHALL be asserted by the consumer to accept a result.
- REQ-016: Port res_sum, output, WIDTH, SHALL carry the result sum.
- REQ-017: Port res_id, output, clog2(NUM_REQ) bits, SHALL identify the requester that owns res_sum.
- REQ-018: Port busy, output, 1 bit, SHALL be high when any operation is in flight or any result is buffered.

Function
- REQ-019: At most one issue SHALL occur per cycle; req_ready SHALL be one-hot or zero, combinational from req_valid, the priority pointer and credits.
- REQ-020: Arbitration SHALL be round-robin: search from pointer ptr upward (mod NUM_REQ); the first valid requester wins.
- REQ-021: On an issue to requester i, ptr SHALL become (i+1) mod NUM_REQ; without an issue, ptr SHALL hold.
- REQ-022: On an issue cycle, csa_in SHALL equal req_vec[grant]; otherwise csa_in SHALL be all zeros.
- REQ-023: A tag shift register, PIPE_LAT stages of {valid, id}, SHALL advance every cycle; stage 0 SHALL load {issue, grant id}.
- REQ-024: When the last tag stage is valid, {csa_s, id} SHALL be pushed into the result FIFO in that same cycle.
- REQ-025: Earliest latency: issue in cycle T gives res_valid=1 in cycle T+PIPE_LAT+1.
- REQ-026: The result FIFO SHALL be first-word-fall-through; res_sum and res_id SHALL be valid whenever res_valid=1.
- REQ-027: A pop SHALL occur on res_valid && res_ready.
- REQ-028: Results SHALL leave in issue order.
- REQ-029: A credit counter SHALL satisfy credits = FIFO_DEPTH - (valid tags + FIFO occupancy).
- REQ-030: The credit counter SHALL decrement by 1 on an issue, increment by 1 on a pop, and hold on a simultaneous issue and pop.
- REQ-031: No grant SHALL be given when credits == 0, so the FIFO never overflows and no result is dropped under any res_ready pattern.
- REQ-032: Issue SHALL be allowed in the same cycle a pop restores a credit from 0 (credit-return bypass).
- REQ-033: A push and a pop in the same cycle SHALL leave occupancy unchanged.
- REQ-034: The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
- REQ-035: Sums SHALL be modulo 2^WIDTH, with no overflow flag.
- REQ-036: req_vec SHALL be sampled only on the issue cycle; a requester holding req_valid with a changing req_vec SHALL not corrupt earlier issues.

Reset
- REQ-037: While rst=1, the block SHALL drive req_ready=0, res_valid=0, busy=0, csa_in=0.
- REQ-038: While rst=1, the block SHALL set ptr=0, clear all tag valids, empty the FIFO and set credits=FIFO_DEPTH.
- REQ-039: Reset asserted mid-operation SHALL discard all in-flight and buffered results, and csa_s values arriving afterward SHALL be ignored.
- REQ-040: The first grant SHALL be possible in the first cycle with rst=0.

Verification
- REQ-041: Single request (defaults): req 0 with operands 1..8, res_ready=1 -> res_valid in cycle T+4, res_sum=36, res_id=0, busy low the cycle after the pop.
- REQ-042: All four requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0,1... one per cycle; res_id follows the same sequence.
- REQ-043: res_ready=0, all requesters valid -> exactly 4 issues, then req_ready=0; FIFO full; raising res_ready yields 4 ordered results, then issue resumes.
- REQ-044: Operands all 0xFFFFFFFF, INPUT_VEC_LEN=8 -> res_sum=0xFFFFFFF8 (wrap).
- REQ-045: rst pulsed for 1 cycle with 2 in flight and 1 buffered -> res_valid=0 next cycle, no stale results afterward, credits=4, ptr=0.
- REQ-046: Random valid/ready traffic for 10k cycles -> results match a scoreboard model in order and id, with no loss or duplication.
